// File: rtl/decoder_rr_arbiter_if.sv
// decoder_rr_arbiter_if: request/release inputs and decoder select/grant outputs of the arbiter
interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [2:0] sel;
  logic       en;
  logic [7:0] gnt_n;
  logic       busy;
  modport master (output req, done, input sel, en, gnt_n, busy);
  modport slave (input req, done, output sel, en, gnt_n, busy);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin 8-way arbiter driving a 3-to-8 decoder, bounded grants with a one-cycle gap
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst_n,
  decoder_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t     state, state_nx;
  logic [2:0] last_idx, last_nx, sel_nx, win;
  logic [7:0] hold_cnt, hold_nx, gnt_nx;
  logic       any_req, release_now, en_nx, busy_nx;
  assign any_req     = |bus.req;
  assign release_now = bus.done || !bus.req[bus.sel] || hold_cnt == 8'(MAX_HOLD - 1);
  // scan farthest offset first so the nearest requester after last_idx wins
  always_comb begin
    win = last_idx;
    for (int k = 8; k >= 1; k--)
      if (bus.req[last_idx + 3'(k)]) win = last_idx + 3'(k);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last_idx  <= 3'd7;
      hold_cnt  <= '0;
      bus.sel   <= '0;
      bus.en    <= 1'b0;
      bus.gnt_n <= 8'hFF;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_nx;
      last_idx  <= last_nx;
      hold_cnt  <= hold_nx;
      bus.sel   <= sel_nx;
      bus.en    <= en_nx;
      bus.gnt_n <= gnt_nx;
      bus.busy  <= busy_nx;
    end
  always_comb begin
    state_nx = state;
    sel_nx   = bus.sel;
    last_nx  = last_idx;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        state_nx = any_req ? GRANT : IDLE;
        sel_nx   = any_req ? win : bus.sel;
        hold_nx  = '0;
      end
      GRANT: begin
        state_nx = release_now ? GAP : GRANT;
        last_nx  = release_now ? bus.sel : last_idx;
        hold_nx  = release_now ? hold_cnt : hold_cnt + 8'd1;
      end
      GAP: begin
        state_nx = any_req ? GRANT : IDLE;
        sel_nx   = any_req ? win : bus.sel;
        hold_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  // outputs are registered, so they are decoded from the next state
  always_comb begin
    en_nx   = state_nx == GRANT;
    busy_nx = state_nx != IDLE;
    gnt_nx  = en_nx ? ~(8'b1 << sel_nx) : 8'hFF;
  end
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed vectors plus a per-cycle behavioural model check of decoder_rr_arbiter
module tb_decoder_rr_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_state = 0;
  int m_sel = 0;
  int m_last = 7;
  int m_run = 0;
  decoder_rr_arbiter_if bus();
  decoder_rr_arbiter #(.MAX_HOLD(MH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic int pick(input int last, input logic [7:0] r);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction
  function automatic logic [7:0] exp_gnt();
    return m_state == 1 ? ~(8'b1 << m_sel) : 8'hFF;
  endfunction
  // model: 0 idle, 1 granting (m_run = cycles granted so far), 2 gap
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_sel = 0; m_last = 7; m_run = 0;
    end else if (m_state == 1) begin
      if (bus.done || !bus.req[m_sel] || m_run == MH) begin
        m_last = m_sel; m_state = 2;
      end else m_run++;
    end else if (bus.req != 8'h00) begin
      m_sel = pick(m_last, bus.req); m_state = 1; m_run = 1;
    end else m_state = 0;
  end
  always @(negedge clk) begin
    chk("model_en", 32'(bus.en), 32'(m_state == 1));
    chk("model_busy", 32'(bus.busy), 32'(m_state != 0));
    chk("model_sel", 32'(bus.sel), 32'(m_sel));
    chk("model_gnt_n", 32'(bus.gnt_n), 32'(exp_gnt()));
    chk("onehot", 32'($countones(~bus.gnt_n) <= 1), 32'd1);
  end
  task automatic step(input logic [7:0] r, input logic d, input logic [7:0] exp, input string name);
    bus.req = r;
    bus.done = d;
    @(posedge clk);
    #1;
    chk(name, 32'(bus.gnt_n), 32'(exp));
  endtask
  initial begin
    bus.req = 8'hFF;
    bus.done = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt_n", 32'(bus.gnt_n), 32'hFF);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step(8'hFF, 1'b0, 8'hFE, "first_grant");
    for (int i = 0; i < 8; i++) begin
      for (int c = (i == 0) ? 1 : 0; c < MH; c++) step(8'hFF, 1'b0, ~(8'b1 << i), "rr_grant");
      step(8'hFF, 1'b0, 8'hFF, "rr_gap");
    end
    step(8'hFF, 1'b0, 8'hFE, "rr_wrap");
    step(8'h08, 1'b0, 8'hFF, "single_gap0");
    repeat (2) begin
      repeat (MH) step(8'h08, 1'b0, 8'hF7, "single_grant");
      step(8'h08, 1'b0, 8'hFF, "single_gap");
    end
    step(8'h08, 1'b0, 8'hF7, "single_regrant");
    step(8'h20, 1'b0, 8'hFF, "early_gap0");
    step(8'h20, 1'b0, 8'hDF, "early_c1");
    step(8'h20, 1'b0, 8'hDF, "early_c2");
    step(8'h20, 1'b1, 8'hFF, "early_done_gap");
    step(8'h20, 1'b0, 8'hDF, "early_regrant");
    step(8'h20, 1'b0, 8'hDF, "early2_c2");
    step(8'h00, 1'b1, 8'hFF, "early2_gap");
    step(8'h00, 1'b0, 8'hFF, "early2_idle");
    chk("idle_busy", 32'(bus.busy), 32'd0);
    step(8'h40, 1'b0, 8'hBF, "wrap_g6");
    repeat (3) step(8'h41, 1'b0, 8'hBF, "wrap_g6_hold");
    step(8'h41, 1'b0, 8'hFF, "wrap_gap");
    repeat (MH) step(8'h41, 1'b0, 8'hFE, "wrap_g0");
    step(8'h41, 1'b0, 8'hFF, "wrap_gap2");
    step(8'h41, 1'b0, 8'hBF, "wrap_back_g6");
    step(8'h10, 1'b0, 8'hFF, "g4_gap");
    step(8'h10, 1'b0, 8'hEF, "g4_c1");
    step(8'h10, 1'b0, 8'hEF, "g4_c2");
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt_n", 32'(bus.gnt_n), 32'hFF);
    chk("async_en", 32'(bus.en), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_sel", 32'(bus.sel), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(8'hFF, 1'b0, 8'hFE, "post_reset_g0");
    repeat (MH - 1) step(8'hFF, 1'b0, 8'hFE, "post_reset_hold");
    step(8'hFF, 1'b1, 8'hFF, "done_and_expiry");
    step(8'hFF, 1'b0, 8'hFD, "next_g1");
    step(8'h00, 1'b0, 8'hFF, "tail_gap");
    step(8'h00, 1'b0, 8'hFF, "tail_idle");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
